sync_fifo_param: RTL and testbench

SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

---
 rtl/sync_fifo_param.sv | 98 +++++++++
 tb/tb_sync_fifo_param.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// Synchronous FIFO with a parameterised depth (any value, not only powers of two).
// Supports an optional fall-through bypass when empty, a synchronous flush and almost-full/almost-empty flags.
module sync_fifo_param #(
  parameter int Width     = 32,
  parameter int Depth     = 4,
  parameter int Pass      = 0,
  parameter int AFullThr  = Depth - 1,
  parameter int AEmptyThr = 1,
  localparam int DW       = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             wvalid_i,
  output logic             wready_o,
  input  logic [Width-1:0] wdata_i,
  output logic             rvalid_o,
  input  logic             rready_i,
  output logic [Width-1:0] rdata_o,
  output logic [DW-1:0]    depth_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             almost_full_o,
  output logic             almost_empty_o
);

  localparam int PW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem [Depth];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [DW-1:0]    occ;
  logic             empty;
  logic             full;
  logic             wr_fire;
  logic             rd_fire;
  logic             bypass;
  logic             do_wr;
  logic             do_rd;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(Depth - 1)) return '0;
    else return p + 1'b1;
  endfunction

  // Flags look only at the registered occupancy, never at the live handshake.
  assign empty          = (occ == '0);
  assign full           = (occ == DW'(Depth));
  assign empty_o        = empty;
  assign full_o         = full;
  assign depth_o        = occ;
  assign almost_full_o  = (occ >= DW'(AFullThr));
  assign almost_empty_o = (occ <= DW'(AEmptyThr));

  // Handshakes are gated by rst_i so they drop immediately on an asynchronous reset.
  assign wready_o = !rst_i && !full && !clr_i;

  always_comb begin
    rvalid_o = !empty && !clr_i && !rst_i;
    rdata_o  = mem[rptr];
    if ((Pass != 0) && empty) begin
      rvalid_o = wvalid_i && !clr_i && !rst_i;
      rdata_o  = wdata_i;
    end
  end

  assign wr_fire = wvalid_i && wready_o;
  assign rd_fire = rvalid_o && rready_i;
  // A word that goes straight through an empty FIFO never touches storage.
  assign bypass  = (Pass != 0) && empty && wr_fire && rd_fire;
  assign do_wr   = wr_fire && !bypass;
  assign do_rd   = rd_fire && !bypass;

  always_ff @(posedge clk_i) begin
    if (do_wr) mem[wptr] <= wdata_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
    end else if (clr_i) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
    end else begin
      if (do_wr) wptr <= ptr_inc(wptr);
      if (do_rd) rptr <= ptr_inc(rptr);
      case ({do_wr, do_rd})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: Depth=4 registered, Depth=4 fall-through and Depth=5 instances
// share one stimulus stream; each phase checks the instance it targets.
module tb_sync_fifo_param;

  logic       clk;
  logic       rst;
  logic       clr;
  logic       wvalid;
  logic       rready;
  logic [7:0] wdata;

  logic       wready0, rvalid0, full0, empty0, afull0, aempty0;
  logic [7:0] rdata0;
  logic [2:0] depth0;
  logic       wready1, rvalid1, full1, empty1, afull1, aempty1;
  logic [7:0] rdata1;
  logic [2:0] depth1;
  logic       wready2, rvalid2, full2, empty2, afull2, aempty2;
  logic [7:0] rdata2;
  logic [2:0] depth2;

  int checks   = 0;
  int failures = 0;

  sync_fifo_param #(.Width(8), .Depth(4), .Pass(0)) u0 (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .wvalid_i(wvalid), .wready_o(wready0),
    .wdata_i(wdata), .rvalid_o(rvalid0), .rready_i(rready), .rdata_o(rdata0),
    .depth_o(depth0), .full_o(full0), .empty_o(empty0),
    .almost_full_o(afull0), .almost_empty_o(aempty0));

  sync_fifo_param #(.Width(8), .Depth(4), .Pass(1)) u1 (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .wvalid_i(wvalid), .wready_o(wready1),
    .wdata_i(wdata), .rvalid_o(rvalid1), .rready_i(rready), .rdata_o(rdata1),
    .depth_o(depth1), .full_o(full1), .empty_o(empty1),
    .almost_full_o(afull1), .almost_empty_o(aempty1));

  sync_fifo_param #(.Width(8), .Depth(5), .Pass(0)) u2 (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .wvalid_i(wvalid), .wready_o(wready2),
    .wdata_i(wdata), .rvalid_o(rvalid2), .rready_i(rready), .rdata_o(rdata2),
    .depth_o(depth2), .full_o(full2), .empty_o(empty2),
    .almost_full_o(afull2), .almost_empty_o(aempty2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset0(input string tag);
    chk1({tag, "_wready"}, wready0, 1'b0);
    chk1({tag, "_rvalid"}, rvalid0, 1'b0);
    chk3({tag, "_depth"},  depth0,  3'd0);
    chk1({tag, "_full"},   full0,   1'b0);
    chk1({tag, "_empty"},  empty0,  1'b1);
    chk1({tag, "_afull"},  afull0,  1'b0);
    chk1({tag, "_aempty"}, aempty0, 1'b1);
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    clr    = 1'b0;
    wvalid = 1'b0;
    rready = 1'b0;
    tick();
    rst = 1'b0;
    #1;
  endtask

  logic [7:0] drain_exp [4];

  initial begin
    rst    = 1'b1;
    clr    = 1'b0;
    wvalid = 1'b0;
    rready = 1'b0;
    wdata  = 8'h00;
    drain_exp[0] = 8'h22;
    drain_exp[1] = 8'h33;
    drain_exp[2] = 8'h44;
    drain_exp[3] = 8'h55;
    #2;
    chk_reset0("rst0");
    tick();
    rst = 1'b0;
    #1;

    // Fill Depth=4 registered FIFO, then full + simultaneous write/read, then drain.
    chk1("t1_idle_rvalid", rvalid0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      wvalid = 1'b1;
      wdata  = 8'(8'h11 * (i + 1));
      #1;
      chk1("t1_wready", wready0, 1'b1);
      tick();
      chk3("t1_depth", depth0, 3'(i + 1));
      if (i == 0) begin
        chk1("t1_lat_rvalid", rvalid0, 1'b1);
        chk8("t1_lat_rdata", rdata0, 8'h11);
        chk1("t1_aempty1", aempty0, 1'b1);
      end
      if (i == 1) chk1("t1_aempty2", aempty0, 1'b0);
    end
    wvalid = 1'b0;
    #1;
    chk1("t1_full", full0, 1'b1);
    chk3("t1_depth4", depth0, 3'd4);
    chk1("t1_wready_full", wready0, 1'b0);
    chk1("t1_afull", afull0, 1'b1);
    wvalid = 1'b1;
    wdata  = 8'h55;
    rready = 1'b1;
    #1;
    chk1("t2_wready_full_rd", wready0, 1'b0);
    chk8("t2_rdata_head", rdata0, 8'h11);
    tick();
    chk3("t2_depth3", depth0, 3'd3);
    chk1("t2_wready_after", wready0, 1'b1);
    rready = 1'b0;
    tick();
    chk3("t2_depth_refill", depth0, 3'd4);
    wvalid = 1'b0;
    rready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk1("t2_drain_rvalid", rvalid0, 1'b1);
      chk8("t2_drain_rdata", rdata0, drain_exp[k]);
      tick();
    end
    rready = 1'b0;
    #1;
    chk1("t2_empty", empty0, 1'b1);
    chk3("t2_depth0", depth0, 3'd0);
    chk1("t2_rvalid0", rvalid0, 1'b0);

    // Fall-through bypass on the Pass=1 instance; Pass=0 instance sees a normal write.
    do_reset();
    wvalid = 1'b1;
    wdata  = 8'hA5;
    rready = 1'b1;
    #1;
    chk1("t3_byp_rvalid", rvalid1, 1'b1);
    chk8("t3_byp_rdata", rdata1, 8'hA5);
    chk1("t3_reg_rvalid", rvalid0, 1'b0);
    tick();
    wvalid = 1'b0;
    rready = 1'b0;
    #1;
    chk3("t3_byp_depth", depth1, 3'd0);
    chk1("t3_byp_empty", empty1, 1'b1);
    chk3("t3_reg_depth", depth0, 3'd1);
    chk8("t3_reg_rdata", rdata0, 8'hA5);
    wvalid = 1'b1;
    clr    = 1'b1;
    #1;
    chk1("t3_clr_rvalid", rvalid1, 1'b0);
    chk1("t3_clr_wready", wready1, 1'b0);
    tick();
    clr    = 1'b0;
    wvalid = 1'b0;
    #1;
    chk3("t3_clr_depth", depth0, 3'd0);

    // Depth=5: steady occupancy 3 across pointer wrap.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      wvalid = 1'b1;
      wdata  = 8'(i + 1);
      tick();
    end
    chk3("t4_prefill", depth2, 3'd3);
    for (int j = 0; j < 9; j++) begin
      wvalid = 1'b1;
      wdata  = 8'(j + 4);
      rready = 1'b1;
      #1;
      chk1("t4_rvalid", rvalid2, 1'b1);
      chk8("t4_rdata", rdata2, 8'(j + 1));
      tick();
      chk3("t4_depth", depth2, 3'd3);
    end
    wvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk8("t4_drain", rdata2, 8'(10 + k));
      tick();
    end
    rready = 1'b0;
    #1;
    chk1("t4_empty", empty2, 1'b1);

    // Flush with simultaneous write at occupancy 3.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      wvalid = 1'b1;
      wdata  = 8'(8'h61 + i);
      tick();
    end
    chk3("t5_occ3", depth0, 3'd3);
    wdata  = 8'h77;
    rready = 1'b1;
    clr    = 1'b1;
    #1;
    chk1("t5_clr_wready", wready0, 1'b0);
    chk1("t5_clr_rvalid", rvalid0, 1'b0);
    tick();
    clr    = 1'b0;
    wvalid = 1'b0;
    rready = 1'b0;
    #1;
    chk3("t5_depth", depth0, 3'd0);
    chk1("t5_empty", empty0, 1'b1);
    chk1("t5_rvalid", rvalid0, 1'b0);
    wvalid = 1'b1;
    wdata  = 8'h88;
    tick();
    wvalid = 1'b0;
    #1;
    chk1("t5_new_rvalid", rvalid0, 1'b1);
    chk8("t5_new_rdata", rdata0, 8'h88);
    chk3("t5_new_depth", depth0, 3'd1);
    rready = 1'b1;
    tick();
    rready = 1'b0;

    // Asynchronous reset between edges at occupancy 2.
    wvalid = 1'b1;
    wdata  = 8'h91;
    tick();
    wdata  = 8'h92;
    tick();
    wvalid = 1'b0;
    chk3("t6_occ2", depth0, 3'd2);
    #2;
    rst = 1'b1;
    #1;
    chk_reset0("t6_async");
    tick();
    rst    = 1'b0;
    wvalid = 1'b1;
    wdata  = 8'h5A;
    #1;
    chk1("t6_wready", wready0, 1'b1);
    tick();
    wvalid = 1'b0;
    #1;
    chk1("t6_rvalid", rvalid0, 1'b1);
    chk8("t6_rdata", rdata0, 8'h5A);
    chk3("t6_depth", depth0, 3'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
